// File: rtl/ped_crossing_controller.sv
// Pedestrian crossing controller: debounced push-button request, walk/flash sequencing
// slaved to the upstream vehicle red phase. Define PED_COUNTDOWN_EN to build the countdown.
module ped_crossing_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 8,
  parameter int FLASH_CYCLES    = 6,
  parameter int BLINK_HALF      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red_light,
  input  logic       yellow_light,
  input  logic       green_light,
  input  logic       ped_button,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_req,
  output logic       fault,
  output logic [7:0] countdown
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam logic [DB_W-1:0] DB_MAX     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_HALF - 1);
  localparam logic [7:0]      WALK_LAST  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0]      FLASH_LAST = 8'(FLASH_CYCLES - 1);

  typedef enum logic [1:0] {DONT_WALK, WALK, FLASH} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            press_reg;
  logic            red_prev_reg;
  logic            fault_reg;
  logic            ped_req_reg, ped_req_next;
  logic [7:0]      timer_reg, timer_next;
  logic [BL_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic            blink_phase_reg, blink_phase_next;

  logic [1:0] light_cnt;
  logic       illegal;
  logic       red_rise;

  assign light_cnt = 2'(red_light) + 2'(yellow_light) + 2'(green_light);
  assign illegal   = (light_cnt > 2'd1);
  assign red_rise  = red_light & ~red_prev_reg;

  // Counter saturates at DEBOUNCE_CYCLES so a held button fires only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg     <= 2'b00;
      db_cnt_reg   <= '0;
      press_reg    <= 1'b0;
      red_prev_reg <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], ped_button};
      press_reg    <= sync_reg[1] && (db_cnt_reg == DB_LAST);
      red_prev_reg <= red_light;
      fault_reg    <= illegal;
      if (!sync_reg[1])
        db_cnt_reg <= '0;
      else if (db_cnt_reg != DB_MAX)
        db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= DONT_WALK;
      ped_req_reg     <= 1'b0;
      timer_reg       <= 8'd0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ped_req_reg     <= ped_req_next;
      timer_reg       <= timer_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ped_req_next     = ped_req_reg | press_reg;
    timer_next       = timer_reg;
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;
    case (state_reg)
      DONT_WALK: begin
        if (!illegal && red_rise && ped_req_reg) begin
          state_next   = WALK;
          timer_next   = 8'd0;
          ped_req_next = press_reg;
        end
      end
      WALK: begin
        if (illegal || !red_light) begin
          state_next = DONT_WALK;
          timer_next = 8'd0;
        end else if (timer_reg == WALK_LAST) begin
          state_next       = FLASH;
          timer_next       = 8'd0;
          blink_cnt_next   = '0;
          blink_phase_next = 1'b0;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      FLASH: begin
        if (illegal || !red_light || timer_reg == FLASH_LAST) begin
          state_next = DONT_WALK;
          timer_next = 8'd0;
        end else begin
          timer_next = timer_reg + 8'd1;
          if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = DONT_WALK;
        timer_next = 8'd0;
      end
    endcase
  end

  assign walk      = (state_reg == WALK);
  assign dont_walk = (state_reg == DONT_WALK) || ((state_reg == FLASH) && !blink_phase_reg);
  assign ped_req   = ped_req_reg;
  assign fault     = fault_reg;

`ifdef PED_COUNTDOWN_EN
  localparam logic [7:0] CD_TOTAL = 8'(WALK_CYCLES + FLASH_CYCLES);
  logic [7:0] countdown_reg, countdown_next;

  always_comb begin
    countdown_next = 8'd0;
    if (state_reg == DONT_WALK && state_next == WALK)
      countdown_next = CD_TOTAL;
    else if (state_next != DONT_WALK && countdown_reg != 8'd0)
      countdown_next = countdown_reg - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      countdown_reg <= 8'd0;
    else
      countdown_reg <= countdown_next;
  end

  assign countdown = countdown_reg;
`else
  assign countdown = 8'd0;
`endif

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Directed bench for ped_crossing_controller: expected lamp/request/fault/countdown
// vectors are queued per step and compared one edge later.
module tb_ped_crossing_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       red_light, yellow_light, green_light, ped_button;
  logic       walk, dont_walk, ped_req, fault;
  logic [7:0] countdown;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb_q[$];

  ped_crossing_controller dut (
    .clk          (clk),
    .reset        (reset),
    .red_light    (red_light),
    .yellow_light (yellow_light),
    .green_light  (green_light),
    .ped_button   (ped_button),
    .walk         (walk),
    .dont_walk    (dont_walk),
    .ped_req      (ped_req),
    .fault        (fault),
    .countdown    (countdown)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cd_exp(input logic [7:0] v);
`ifdef PED_COUNTDOWN_EN
    return v;
`else
    return 8'd0;
`endif
  endfunction

  // Queue the expectation, advance one edge, then compare the DUT against it.
  task automatic step(input string tag, input logic w, input logic dw,
                      input logic rq, input logic ft, input logic [7:0] cdv);
    exp_t        e;
    exp_t        got;
    logic [11:0] obs;
    e.tag = tag;
    e.val = {w, dw, rq, ft, cd_exp(cdv)};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    obs = {walk, dont_walk, ped_req, fault, countdown};
    checks++;
    assert (obs === got.val)
    else begin
      errors++;
      $error("FAIL %s observed w/dw/req/flt/cd=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
             got.tag, obs[11], obs[10], obs[9], obs[8], obs[7:0],
             got.val[11], got.val[10], got.val[9], got.val[8], got.val[7:0]);
    end
    assert (!(walk && dont_walk))
    else begin
      errors++;
      $error("FAIL exclusive_lamps observed walk=%b dont_walk=%b required not both", walk, dont_walk);
    end
    $display("step %-12s w=%b dw=%b req=%b flt=%b cd=%0d", got.tag, walk, dont_walk, ped_req, fault, countdown);
  endtask

  int flash_dw[6] = '{1, 1, 0, 0, 1, 1};

  initial begin
    reset = 1'b1; red_light = 1'b1; yellow_light = 1'b0; green_light = 1'b0; ped_button = 1'b1;

    // Reset dominates red and button
    for (int i = 0; i < 5; i++) step("reset", 0, 1, 0, 0, 0);

    reset = 1'b0; red_light = 1'b0; green_light = 1'b1; ped_button = 1'b0;
    for (int i = 0; i < 2; i++) step("idle", 0, 1, 0, 0, 0);

    // Debounced press: request on 7th edge after button rise
    ped_button = 1'b1;
    for (int k = 1; k <= 10; k++) step("press_lat", 0, 1, (k >= 7), 0, 0);
    ped_button = 1'b0;
    for (int i = 0; i < 2; i++) step("req_hold", 0, 1, 1, 0, 0);

    // Full crossing cycle on red rise
    green_light = 1'b0; red_light = 1'b1;
    for (int k = 0; k < 8; k++) step("walk", 1, 0, 0, 0, 8'(14 - k));
    for (int k = 0; k < 6; k++) step("flash", 0, flash_dw[k][0], 0, 0, 8'(6 - k));
    for (int i = 0; i < 3; i++) step("done", 0, 1, 0, 0, 0);

    // Short pulse ignored
    red_light = 1'b0; green_light = 1'b1;
    step("green", 0, 1, 0, 0, 0);
    ped_button = 1'b1;
    for (int i = 0; i < 3; i++) step("short_pls", 0, 1, 0, 0, 0);
    ped_button = 1'b0;
    for (int i = 0; i < 6; i++) step("short_wait", 0, 1, 0, 0, 0);
    green_light = 1'b0; red_light = 1'b1;
    for (int i = 0; i < 4; i++) step("no_walk", 0, 1, 0, 0, 0);

    // Request while red already high waits for next rise; then abort in 3rd WALK cycle
    ped_button = 1'b1;
    for (int k = 1; k <= 10; k++) step("red_press", 0, 1, (k >= 7), 0, 0);
    ped_button = 1'b0;
    for (int i = 0; i < 2; i++) step("red_wait", 0, 1, 1, 0, 0);
    red_light = 1'b0; green_light = 1'b1;
    step("red_drop", 0, 1, 1, 0, 0);
    green_light = 1'b0; red_light = 1'b1;
    for (int k = 0; k < 3; k++) step("walk2", 1, 0, 0, 0, 8'(14 - k));
    red_light = 1'b0; green_light = 1'b1;
    step("abort", 0, 1, 0, 0, 0);
    step("abort_hold", 0, 1, 0, 0, 0);

    // Illegal red+green during WALK
    ped_button = 1'b1;
    for (int k = 1; k <= 10; k++) step("press3", 0, 1, (k >= 7), 0, 0);
    ped_button = 1'b0;
    green_light = 1'b0; red_light = 1'b1;
    step("walk3", 1, 0, 0, 0, 14);
    green_light = 1'b1;
    step("fault_hi", 0, 1, 0, 1, 0);
    green_light = 1'b0;
    step("fault_clr", 0, 1, 0, 0, 0);
    step("no_rewalk", 0, 1, 0, 0, 0);

    // Held button does not re-trigger after being served
    ped_button = 1'b1;
    for (int k = 1; k <= 10; k++) step("held", 0, 1, (k >= 7), 0, 0);
    red_light = 1'b0; green_light = 1'b1;
    step("held_green", 0, 1, 1, 0, 0);
    green_light = 1'b0; red_light = 1'b1;
    for (int k = 0; k < 5; k++) step("held_walk", 1, 0, 0, 0, 8'(14 - k));

    // Reset mid-walk; after release with red high, no walk until next rise
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step("mid_reset", 0, 1, 0, 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) step("post_reset", 0, 1, (k >= 7), 0, 0);
    ped_button = 1'b0;
    red_light = 1'b0; green_light = 1'b1;
    step("final_grn", 0, 1, 1, 0, 0);
    green_light = 1'b0; red_light = 1'b1;
    step("final_walk", 1, 0, 0, 0, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ped_crossing_controller.md
PED_CROSSING_CONTROLLER -- requirements
Module: ped_crossing_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEBOUNCE_CYCLES  4  consecutive synchronized-high cycles that qualify a press
  WALK_CYCLES      8  steady-walk duration in clk cycles
  FLASH_CYCLES     6  flashing don't-walk duration in clk cycles
  BLINK_HALF       2  flash half-period in clk cycles
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk              in   1  single clock, all logic on rising edge
  reset            in   1  synchronous, active-high reset
  red_light        in   1  vehicle red from the upstream traffic light controller
  yellow_light     in   1  vehicle yellow from the upstream controller
  green_light      in   1  vehicle green from the upstream controller
  ped_button       in   1  raw pedestrian push-button, asynchronous to clk
  walk             out  1  walk lamp
  dont_walk        out  1  don't-walk lamp, steady or blinking
  ped_req          out  1  latched pending pedestrian request
  fault            out  1  illegal vehicle-light combination seen
  countdown        out  8  remaining crossing cycles (see REQ-019)
REQ-003 Parameters SHALL satisfy WALK_CYCLES+FLASH_CYCLES <= 255 and all parameters >= 1.

Function
REQ-004 ped_button SHALL pass through a 2-flop synchronizer before any use.
REQ-005 A press SHALL be detected once, when the synchronized level has been high for exactly DEBOUNCE_CYCLES consecutive cycles; shorter pulses SHALL be ignored, and a held button SHALL NOT re-trigger until it is low for at least 1 cycle.
REQ-006 A detected press SHALL set ped_req on the next edge, in any state, including WALK and FLASH, which serves the following red phase.
REQ-007 The block SHALL register red_light each cycle (red_prev); a red rising edge is red_light=1 with red_prev=0.
REQ-008 FSM states SHALL be DONT_WALK, WALK, FLASH, with Moore outputs decoded from the state register.
REQ-009 DONT_WALK->WALK SHALL occur on the edge that samples a red rising edge while ped_req=1; ped_req SHALL clear on that same edge unless a new press is detected in that cycle.
REQ-010 A request arriving while red is already high SHALL wait for the next red rising edge.
REQ-011 WALK SHALL last exactly WALK_CYCLES cycles, then FLASH; FLASH SHALL last exactly FLASH_CYCLES cycles, then DONT_WALK.
REQ-012 Outputs: DONT_WALK walk=0, dont_walk=1; WALK walk=1, dont_walk=0; FLASH walk=0, dont_walk=1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating from FLASH entry.
REQ-013 If red_light is sampled 0 in WALK or FLASH, the next state SHALL be DONT_WALK (abort); ped_req SHALL NOT be re-set by the abort.
REQ-014 fault SHALL be registered, and high for each cycle after one in which more than one of red/yellow/green was sampled high.
REQ-015 While an illegal combination is sampled, the FSM SHALL go to or stay in DONT_WALK; all-low lights SHALL be treated as not-red with no fault.
REQ-016 walk and dont_walk SHALL never be high together.

Reset
REQ-017 With reset sampled high: state=DONT_WALK, walk=0, dont_walk=1, ped_req=0, fault=0, countdown=0, and the synchronizer, debounce counter, phase timer and red_prev all clear to 0.
REQ-018 Reset SHALL override every other event in the same cycle. After release with red already high, no walk SHALL be granted until the next red rising edge.

Configuration
REQ-019 With macro PED_COUNTDOWN_EN defined, countdown SHALL equal WALK_CYCLES+FLASH_CYCLES on WALK entry, decrement by 1 per cycle through WALK and FLASH (1 in the last FLASH cycle), and be 0 in DONT_WALK and on abort.
REQ-020 Without PED_COUNTDOWN_EN, the countdown port SHALL remain present and be tied to 0, and no countdown register SHALL be built.

Verification (default parameters)
REQ-021 reset=1 with red_light=1, ped_button=1 for 5 cycles -> walk=0, dont_walk=1, ped_req=0, fault=0, countdown=0 throughout.
REQ-022 green=1, button high 10 cycles -> ped_req=1 exactly 7 edges after button rise; red rises -> walk=1 for 8 cycles, then dont_walk 1,1,0,0,1,1, then steady 1; ped_req=0 from WALK entry.
REQ-023 button high 3 cycles during green, then red rises -> ped_req stays 0, walk never asserts.
REQ-024 red_light drops in 3rd WALK cycle -> walk=0, dont_walk=1 next edge, countdown=0.
REQ-025 red=1 and green=1 for 1 cycle during WALK -> fault=1 for one cycle, DONT_WALK next edge.
REQ-026 PED_COUNTDOWN_EN defined: countdown 14 on WALK entry, down to 1 on last FLASH cycle, then 0; macro undefined: countdown=0 always.
